// File: rtl/special_alu_pkg.sv
// special_alu_pkg: shared types and sizing for the operand-buffering ALU.
//   DEPTH - operand buffer entries (fixed at 8 so results fit in 11 bits)
//   OPW   - operand width, RESW - result width
//   opcode_e - B-port operation codes, state_e - response FSM states
//   avg_floor - floor average with a zero-count guard
package special_alu_pkg;

  localparam int DEPTH = 8;
  localparam int OPW   = 8;
  localparam int RESW  = 11;
  localparam int PTRW  = 3;  // log2(DEPTH)
  localparam int CNTW  = 4;  // holds 0..DEPTH

  typedef enum logic [2:0] {
    OP_SUM   = 3'd0,
    OP_MAX   = 3'd1,
    OP_MIN   = 3'd2,
    OP_COUNT = 3'd3,
    OP_AVG   = 3'd4,
    OP_LAST  = 3'd5,
    OP_POP   = 3'd6,
    OP_CLEAR = 3'd7
  } opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Empty buffer averages to zero rather than dividing by zero.
  function automatic logic [RESW-1:0] avg_floor(input logic [RESW-1:0] sum,
                                                input logic [CNTW-1:0] cnt);
    if (cnt == '0) return '0;
    return sum / RESW'(cnt);
  endfunction

endpackage

// File: rtl/special_alu_if.sv
// special_alu_if: the two streaming ports of special_alu.
//   A port (operand sink):  a_valid, a_operand -> ALU ; a_ready <- ALU
//   B port (request/resp):  b_valid, b_operation -> ALU ; b_ready, b_result <- ALU
//   master: operand producer / requester side; slave: the ALU side.
interface special_alu_if;
  import special_alu_pkg::*;

  logic            a_valid;
  logic [OPW-1:0]  a_operand;
  logic            a_ready;
  logic            b_valid;
  logic [2:0]      b_operation;
  logic            b_ready;
  logic [RESW-1:0] b_result;

  modport master (
    output a_valid, a_operand, b_valid, b_operation,
    input  a_ready, b_ready, b_result
  );

  modport slave (
    input  a_valid, a_operand, b_valid, b_operation,
    output a_ready, b_ready, b_result
  );
endinterface

// File: rtl/special_alu_fifo.sv
// special_alu_fifo: 8x8 circular operand buffer.
//   clk, rstn     - clock, synchronous active-high reset
//   push_i/push_data_i - append at tail (ignored when full)
//   pop_i         - drop oldest entry (ignored when empty)
//   clear_i       - empty the buffer
//   entries_o     - raw storage, slot-indexed
//   valid_o       - per-slot occupancy mask
//   count_o, oldest_o, last_o - occupancy, head entry, most recent push
module special_alu_fifo
  import special_alu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [OPW-1:0]             push_data_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [DEPTH-1:0][OPW-1:0]  entries_o,
  output logic [DEPTH-1:0]           valid_o,
  output logic [CNTW-1:0]            count_o,
  output logic [OPW-1:0]             oldest_o,
  output logic [OPW-1:0]             last_o
);

  logic [OPW-1:0]  mem_q [DEPTH];
  logic [PTRW-1:0] head_q, tail_q;
  logic [CNTW-1:0] count_q;
  logic [PTRW-1:0] last_ptr;
  logic            do_push, do_pop;

  assign do_push  = push_i && (count_q != CNTW'(DEPTH));
  assign do_pop   = pop_i && (count_q != '0);
  assign last_ptr = tail_q - PTRW'(1);

  // Storage content needs no reset: the valid mask hides stale slots.
  always_ff @(posedge clk) begin
    if (do_push && !rstn && !clear_i) mem_q[tail_q] <= push_data_i;
  end

  // Pointers are PTRW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rstn || clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + PTRW'(1);
      if (do_pop)  head_q <= head_q + PTRW'(1);
      count_q <= count_q + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

  // A slot is live when its distance from head is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTRW-1:0] offset;
    assign offset        = PTRW'(gi) - head_q;
    assign entries_o[gi] = mem_q[gi];
    assign valid_o[gi]   = ({1'b0, offset} < count_q);
  end

  assign count_o  = count_q;
  assign oldest_o = mem_q[head_q];
  assign last_o   = mem_q[last_ptr];

endmodule

// File: rtl/special_alu.sv
// special_alu: operand-buffering ALU.
//   clk  - clock, rising edge
//   rstn - synchronous reset, active-high despite its name
//   bus  - special_alu_if.slave: A operand sink, B request/response port
// A request sampled in IDLE is answered with a one-cycle b_ready in the
// following cycle (RESP); POP/CLEAR side effects land at the end of RESP.
module special_alu
  import special_alu_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  special_alu_if.slave bus
);

  state_e          state_q;
  opcode_e         op_q;
  logic            b_ready_q;
  logic [RESW-1:0] b_result_q;
  logic [RESW-1:0] result_d;

  logic [DEPTH-1:0][OPW-1:0] entries;
  logic [DEPTH-1:0]          valid;
  logic [CNTW-1:0]           count;
  logic [OPW-1:0]            oldest, last;
  logic                      push, pop, clear;
  opcode_e                   op_in;

  // Pushes are stalled whenever a B operation is pending or responding, so
  // the contents seen by the reduction stay fixed across the request.
  assign bus.a_ready = !rstn && (state_q == IDLE) && !bus.b_valid &&
                       (count < CNTW'(DEPTH));
  assign push  = bus.a_valid && bus.a_ready;
  assign pop   = (state_q == RESP) && (op_q == OP_POP);
  assign clear = (state_q == RESP) && (op_q == OP_CLEAR);
  assign op_in = opcode_e'(bus.b_operation);

  special_alu_fifo u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push),
    .push_data_i (bus.a_operand),
    .pop_i       (pop),
    .clear_i     (clear),
    .entries_o   (entries),
    .valid_o     (valid),
    .count_o     (count),
    .oldest_o    (oldest),
    .last_o      (last)
  );

  logic [RESW-1:0] sum_c;
  logic [OPW-1:0]  max_c, min_c;

  always_comb begin
    sum_c = '0;
    max_c = '0;
    min_c = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        sum_c = sum_c + RESW'(entries[i]);
        if (entries[i] > max_c) max_c = entries[i];
        if (entries[i] < min_c) min_c = entries[i];
      end
    end
  end

  always_comb begin
    result_d = '0;
    unique case (op_in)
      OP_SUM:   result_d = sum_c;
      OP_MAX:   result_d = RESW'(max_c);
      OP_MIN:   result_d = (count == '0) ? '0 : RESW'(min_c);
      OP_COUNT: result_d = RESW'(count);
      OP_AVG:   result_d = avg_floor(sum_c, count);
      OP_LAST:  result_d = (count == '0) ? '0 : RESW'(last);
      OP_POP:   result_d = (count == '0) ? '0 : RESW'(oldest);
      OP_CLEAR: result_d = RESW'(count);
      default:  result_d = '0;
    endcase
  end

  // Response FSM with registered outputs; reset aborts any pending response.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= IDLE;
      op_q       <= OP_SUM;
      b_ready_q  <= 1'b0;
      b_result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.b_valid) begin
            b_result_q <= result_d;
            op_q       <= op_in;
            b_ready_q  <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          b_ready_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          b_ready_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.b_ready  = b_ready_q;
  assign bus.b_result = b_result_q;

endmodule

// File: tb/tb_special_alu.sv
module tb_special_alu;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   q[$];

  always #5 clk = ~clk;

  special_alu_if bus_if ();

  special_alu dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  // Reference model: results straight from the operation definitions.
  function automatic int model_result(input int op);
    int s, mx, mn;
    s = 0; mx = 0; mn = 255;
    foreach (q[i]) begin
      s += q[i];
      if (q[i] > mx) mx = q[i];
      if (q[i] < mn) mn = q[i];
    end
    case (op)
      0: return s;
      1: return mx;
      2: return (q.size() == 0) ? 0 : mn;
      3: return q.size();
      4: return (q.size() == 0) ? 0 : s / q.size();
      5: return (q.size() == 0) ? 0 : q[$];
      6: return (q.size() == 0) ? 0 : q[0];
      default: return q.size();
    endcase
  endfunction

  function automatic void model_apply(input int op);
    if (op == 6 && q.size() != 0) void'(q.pop_front());
    if (op == 7) q.delete();
  endfunction

  // Offer one operand for a single edge; returns sampled a_ready.
  task automatic drive_push(input int v, output logic rdy);
    @(negedge clk);
    bus_if.a_valid   = 1'b1;
    bus_if.a_operand = 8'(v);
    #1;
    rdy = bus_if.a_ready;
    @(posedge clk);
    #1;
    bus_if.a_valid = 1'b0;
    if (q.size() < 8) q.push_back(v);
    $display("[TB] push %0d a_ready=%0b model_count=%0d", v, rdy, q.size());
  endtask

  // Issue one request; samples the RESP cycle and the cycle after it.
  task automatic drive_req(input int op, output int expv, output logic r1,
                           output logic [10:0] res1, output logic r2,
                           output logic [10:0] res2, output logic ar);
    @(negedge clk);
    bus_if.b_valid     = 1'b1;
    bus_if.b_operation = 3'(op);
    expv = model_result(op);
    @(posedge clk);
    #1;
    r1 = bus_if.b_ready;
    res1 = bus_if.b_result;
    ar = bus_if.a_ready;
    bus_if.b_valid = 1'b0;
    @(posedge clk);
    #1;
    r2 = bus_if.b_ready;
    res2 = bus_if.b_result;
    model_apply(op);
    $display("[TB] op=%0d result=%0d expected=%0d b_ready=%0b", op, res1, expv, r1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b1;
    bus_if.a_valid = 1'b0;
    bus_if.b_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus_if.a_valid = 1'b1;
    bus_if.a_operand = 8'd9;
    #1;
    tests_run++;
    if (bus_if.a_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_a_ready got=%0b exp=0", bus_if.a_ready);
    end
    tests_run++;
    if (bus_if.b_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_b_ready got=%0b exp=0", bus_if.b_ready);
    end
    tests_run++;
    if (bus_if.b_result !== 11'd0) begin
      tests_failed++; $display("FAIL reset_b_result got=%0d exp=0", bus_if.b_result);
    end
    bus_if.a_valid = 1'b0;
    do_reset();
    #1;
    tests_run++;
    if (bus_if.a_ready !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset_a_ready got=%0b exp=1", bus_if.a_ready);
    end
  endtask

  task automatic test_empty();
    int ops[3] = '{3, 0, 4};
    int e; logic r1, r2, ar; logic [10:0] s1, s2;
    foreach (ops[i]) begin
      drive_req(ops[i], e, r1, s1, r2, s2, ar);
      tests_run++;
      if (r1 !== 1'b1 || s1 !== 11'd0 || r2 !== 1'b0) begin
        tests_failed++;
        $display("FAIL empty_op%0d got ready=%0b res=%0d next_ready=%0b exp 1/0/0",
                 ops[i], r1, s1, r2);
      end
    end
  endtask

  task automatic test_basic();
    int vals[4] = '{10, 20, 30, 40};
    int want[6] = '{100, 40, 10, 3, 25, 40};
    int e; logic rdy, r1, r2, ar; logic [10:0] s1, s2;
    foreach (vals[i]) drive_push(vals[i], rdy);
    for (int op = 0; op < 6; op++) begin
      drive_req(op, e, r1, s1, r2, s2, ar);
      if (op == 3) e = 4;
      else e = want[op];
      tests_run++;
      if (r1 !== 1'b1 || s1 !== 11'(e)) begin
        tests_failed++; $display("FAIL basic_op%0d got ready=%0b res=%0d exp 1/%0d", op, r1, s1, e);
      end
      tests_run++;
      if (r2 !== 1'b0 || s2 !== 11'(e)) begin
        tests_failed++; $display("FAIL basic_hold_op%0d got ready=%0b res=%0d exp 0/%0d", op, r2, s2, e);
      end
    end
  endtask

  task automatic test_full();
    int e; logic rdy, r1, r2, ar; logic [10:0] s1, s2;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_push(255, rdy);
      tests_run++;
      if (rdy !== (i < 8)) begin
        tests_failed++; $display("FAIL full_push%0d a_ready got=%0b exp=%0b", i, rdy, i < 8);
      end
    end
    drive_req(0, e, r1, s1, r2, s2, ar);
    tests_run++;
    if (s1 !== 11'h7F8 || e != 2040) begin
      tests_failed++; $display("FAIL full_sum got=%0d exp=2040", s1);
    end
  endtask

  task automatic test_pop();
    int vals[3] = '{5, 7, 9};
    int seq_op[5] = '{6, 6, 3, 6, 6};
    int seq_exp[5] = '{5, 7, 1, 9, 0};
    int e; logic rdy, r1, r2, ar; logic [10:0] s1, s2;
    do_reset();
    foreach (vals[i]) drive_push(vals[i], rdy);
    foreach (seq_op[i]) begin
      drive_req(seq_op[i], e, r1, s1, r2, s2, ar);
      tests_run++;
      if (r1 !== 1'b1 || s1 !== 11'(seq_exp[i]) || e != seq_exp[i]) begin
        tests_failed++; $display("FAIL pop_step%0d got=%0d exp=%0d", i, s1, seq_exp[i]);
      end
    end
    drive_req(3, e, r1, s1, r2, s2, ar);
    tests_run++;
    if (s1 !== 11'd0) begin
      tests_failed++; $display("FAIL pop_empty_count got=%0d exp=0", s1);
    end
  endtask

  task automatic test_clear();
    int e; logic rdy, r1, r2, ar; logic [10:0] s1, s2;
    for (int i = 0; i < 3; i++) drive_push(11 * (i + 1), rdy);
    drive_req(7, e, r1, s1, r2, s2, ar);
    tests_run++;
    if (s1 !== 11'd3) begin
      tests_failed++; $display("FAIL clear_result got=%0d exp=3", s1);
    end
    drive_req(3, e, r1, s1, r2, s2, ar);
    tests_run++;
    if (s1 !== 11'd0) begin
      tests_failed++; $display("FAIL clear_count got=%0d exp=0", s1);
    end
    drive_push(42, rdy);
    tests_run++;
    if (rdy !== 1'b1) begin
      tests_failed++; $display("FAIL clear_resume a_ready got=%0b exp=1", rdy);
    end
  endtask

  task automatic test_stall();
    int e; logic r1, r2, ar; logic [10:0] s1, s2;
    @(negedge clk);
    bus_if.a_valid = 1'b1;
    bus_if.a_operand = 8'd77;
    bus_if.b_valid = 1'b1;
    bus_if.b_operation = 3'd3;
    #1;
    tests_run++;
    if (bus_if.a_ready !== 1'b0) begin
      tests_failed++; $display("FAIL stall_req a_ready got=%0b exp=0", bus_if.a_ready);
    end
    @(posedge clk);
    #1;
    bus_if.b_valid = 1'b0;
    #1;
    tests_run++;
    if (bus_if.b_ready !== 1'b1 || bus_if.a_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_resp got b_ready=%0b a_ready=%0b exp 1/0", bus_if.b_ready, bus_if.a_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus_if.a_ready !== 1'b1) begin
      tests_failed++; $display("FAIL stall_release a_ready got=%0b exp=1", bus_if.a_ready);
    end
    bus_if.a_valid = 1'b0;
    drive_req(3, e, r1, s1, r2, s2, ar);
    tests_run++;
    if (s1 !== 11'(e) || ar !== 1'b0) begin
      tests_failed++; $display("FAIL stall_count got=%0d a_ready=%0b exp %0d/0", s1, ar, e);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    e = model_result(3);
    @(negedge clk);
    bus_if.b_valid = 1'b1;
    bus_if.b_operation = 3'd3;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus_if.b_ready !== ((k % 2) == 0) || bus_if.b_result !== 11'(e)) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d got ready=%0b res=%0d exp %0b/%0d",
                 k, bus_if.b_ready, bus_if.b_result, (k % 2) == 0, e);
      end
    end
    bus_if.b_valid = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus_if.b_ready !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_end got ready=%0b exp=0", bus_if.b_ready);
    end
    $display("[TB] back-to-back count=%0d", e);
  endtask

  task automatic test_reset_resp();
    int e; logic rdy, r1, r2, ar; logic [10:0] s1, s2;
    drive_push(60, rdy);
    @(negedge clk);
    bus_if.b_valid = 1'b1;
    bus_if.b_operation = 3'd6;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus_if.b_valid = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus_if.b_ready !== 1'b0 || bus_if.b_result !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_resp got ready=%0b res=%0d exp 0/0", bus_if.b_ready, bus_if.b_result);
    end
    @(negedge clk);
    rstn = 1'b0;
    q.delete();
    drive_req(3, e, r1, s1, r2, s2, ar);
    tests_run++;
    if (s1 !== 11'd0) begin
      tests_failed++; $display("FAIL reset_resp_count got=%0d exp=0", s1);
    end
  endtask

  task automatic test_random();
    int e, v, op; logic rdy, r1, r2, ar; logic [10:0] s1, s2; logic exp_rdy;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        v = int'($urandom_range(0, 255));
        exp_rdy = (q.size() < 8);
        drive_push(v, rdy);
        tests_run++;
        if (rdy !== exp_rdy) begin
          tests_failed++; $display("FAIL rand_push%0d a_ready got=%0b exp=%0b", n, rdy, exp_rdy);
        end
      end else begin
        op = int'($urandom_range(0, 7));
        drive_req(op, e, r1, s1, r2, s2, ar);
        tests_run++;
        if (r1 !== 1'b1 || s1 !== 11'(e) || r2 !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand_op%0d step%0d got ready=%0b res=%0d exp 1/%0d", op, n, r1, s1, e);
        end
      end
    end
  endtask

  initial begin
    bus_if.a_valid = 1'b0;
    bus_if.a_operand = '0;
    bus_if.b_valid = 1'b0;
    bus_if.b_operation = '0;
    test_reset();
    test_empty();
    test_basic();
    test_full();
    test_pop();
    test_clear();
    test_stall();
    test_back_to_back();
    test_reset_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
